// File: rtl/sram_fetch_unit_pkg.sv
// Shared types and constants for the SRAM instruction-fetch front end.
package fetch_pkg;
   localparam int unsigned     PC_W             = 32;
   localparam int unsigned     DATA_W           = 32;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/sram_fetch_unit_if.sv
// Core-side instruction handshake: {pc, instr} with valid/ready.
interface sram_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr_data;
   logic [31:0]           instr_pc;

   modport master (output instr_valid, output instr_data, output instr_pc, input instr_ready);
   modport slave  (input instr_valid, input instr_data, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry push/pop FIFO of fetch entries; flush wins over push and pop.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);
   fetch_entry_t mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/sram_fetch_unit.sv
// Instruction-fetch front end driving the read-only port of the instruction SRAM.
module sram_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   sram_fetch_unit_if.master      core,
   output logic                   fault,
   output logic                   sram_csb,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);
   logic [31:0]  fetch_pc;
   logic [31:0]  inflight_pc;
   logic         inflight;
   logic         pop;
   logic         issue;
   logic         capture;
   logic [2:0]   credit;
   logic [1:0]   count;
   fetch_entry_t head;
   fetch_entry_t push_data;

   assign pop    = core.instr_valid & core.instr_ready;
   // Slots already claimed after this cycle's pop; keeps room for every in-flight response.
   assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue  = rst_n && !redirect_valid && (credit < 3'd2);

   assign sram_csb  = ~issue;
   assign sram_addr = fetch_pc[ADDR_WIDTH+1:2];

   // SRAM data is only valid up to this edge, so capture ignores back-pressure.
   assign capture        = inflight && !redirect_valid;
   assign push_data.pc    = inflight_pc;
   assign push_data.instr = sram_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         fault       <= 1'b0;
      end else begin
         fault <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
         end else begin
            inflight <= issue;
            if (issue) begin
               fetch_pc    <= fetch_pc + 32'd4;
               inflight_pc <= fetch_pc;
            end
         end
      end
   end

   fetch_skid_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (capture),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign core.instr_valid = (count != 2'd0);
   assign core.instr_data  = head.instr;
   assign core.instr_pc    = head.pc;
endmodule

// File: tb/tb_sram_fetch_unit.sv
// Scoreboard bench for sram_fetch_unit with a behavioural 32x256 SRAM read port.
module tb_sram_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fault;
   logic        sram_csb;
   logic [7:0]  sram_addr;
   logic [31:0] sram_dout;

   sram_fetch_unit_if #(.DATA_WIDTH(32)) core_if ();

   sram_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .core           (core_if),
      .fault          (fault),
      .sram_csb       (sram_csb),
      .sram_addr      (sram_addr),
      .sram_dout      (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]  mem [256];
   logic         rd_pend;
   logic [7:0]   rd_addr;
   fetch_entry_t sb [$];
   int           total;
   int           bad;
   int           acc;

   // SRAM port: sample at posedge, data from the next negedge, garbage after the following posedge.
   always @(posedge clk) begin
      rd_pend <= !sram_csb;
      rd_addr <= sram_addr;
   end
   always @(negedge clk) if (rd_pend) sram_dout = mem[rd_addr];
   always @(posedge clk) begin
      #1;
      sram_dout = 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      if (rst_n && !redirect_valid && core_if.instr_valid && core_if.instr_ready) begin
         fetch_entry_t e;
         total++;
         acc++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got pc=%h instr=%h, required none", core_if.instr_pc, core_if.instr_data);
         end else begin
            e = sb.pop_front();
            if (core_if.instr_pc !== e.pc || core_if.instr_data !== e.instr) begin
               bad++;
               $display("FAIL sb_entry got pc=%h instr=%h, required pc=%h instr=%h",
                        core_if.instr_pc, core_if.instr_data, e.pc, e.instr);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic [31:0] start);
      logic [31:0] pc;
      sb.delete();
      pc = start;
      for (int i = 0; i < 64; i++) begin
         fetch_entry_t e;
         e.pc    = pc;
         e.instr = mem[pc[9:2]];
         sb.push_back(e);
         pc = pc + 32'd4;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (sram_csb !== 1'b1) begin bad++; $display("FAIL rst_csb got %b required 1", sram_csb); end
      total++; if (sram_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got %h required 00", sram_addr); end
      total++; if (core_if.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", core_if.instr_valid); end
      total++; if (core_if.instr_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h required 0", core_if.instr_data); end
      total++; if (core_if.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got %h required 0", core_if.instr_pc); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got %b required 0", fault); end
      push_stream(32'h0);
      step();
      rst_n = 1'b1;
      core_if.instr_ready = 1'b1;
      @(negedge clk);
      total++; if (sram_csb !== 1'b0) begin bad++; $display("FAIL first_csb got %b required 0", sram_csb); end
      total++; if (sram_addr !== 8'd0) begin bad++; $display("FAIL first_addr got %h required 00", sram_addr); end
   endtask

   task automatic test_stream();
      int n;
      n = 0;
      while (!core_if.instr_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (!core_if.instr_valid) begin bad++; $display("FAIL stream_timeout got valid=0 required 1 within 20 cycles"); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (core_if.instr_valid !== 1'b1) begin bad++; $display("FAIL stream_gap cycle %0d got valid=%b required 1", i, core_if.instr_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hold_pc, hold_data;
      step();
      core_if.instr_ready = 1'b0;
      @(negedge clk);
      hold_pc   = core_if.instr_pc;
      hold_data = core_if.instr_data;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (core_if.instr_valid !== 1'b1 || core_if.instr_pc !== hold_pc || core_if.instr_data !== hold_data) begin
            bad++;
            $display("FAIL bp_hold got v=%b pc=%h d=%h required v=1 pc=%h d=%h",
                     core_if.instr_valid, core_if.instr_pc, core_if.instr_data, hold_pc, hold_data);
         end
         total++; if (sram_csb !== 1'b1) begin bad++; $display("FAIL bp_csb got %b required 1", sram_csb); end
      end
      step();
      core_if.instr_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 20 && acc < 8; i++) @(negedge clk);
      total++; if (acc < 8) begin bad++; $display("FAIL bp_resume got %0d accepts required 8", acc); end
   endtask

   task automatic do_redirect(input logic [31:0] target);
      step();
      core_if.instr_ready = 1'b0;
      repeat (3) step();
      redirect_valid = 1'b1;
      redirect_pc    = target;
      push_stream({target[31:2], 2'b00});
      @(negedge clk);
      total++; if (sram_csb !== 1'b1) begin bad++; $display("FAIL redir_csb got %b required 1", sram_csb); end
      step();
      redirect_valid      = 1'b0;
      core_if.instr_ready = 1'b1;
   endtask

   task automatic test_redirect();
      do_redirect(32'h40);
      @(negedge clk);
      total++; if (core_if.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got valid=%b required 0", core_if.instr_valid); end
      acc = 0;
      for (int i = 0; i < 20 && acc < 4; i++) @(negedge clk);
      total++; if (acc < 4) begin bad++; $display("FAIL redir_timeout got %0d accepts required 4", acc); end
   endtask

   task automatic test_wrap();
      do_redirect(32'h3FC);
      @(negedge clk);
      total++; if (sram_csb !== 1'b0 || sram_addr !== 8'd255) begin bad++; $display("FAIL wrap_addr0 got csb=%b addr=%0d required 0/255", sram_csb, sram_addr); end
      @(negedge clk);
      total++; if (sram_csb !== 1'b0 || sram_addr !== 8'd0) begin bad++; $display("FAIL wrap_addr1 got csb=%b addr=%0d required 0/0", sram_csb, sram_addr); end
      acc = 0;
      for (int i = 0; i < 20 && acc < 3; i++) @(negedge clk);
      total++; if (acc < 3) begin bad++; $display("FAIL wrap_timeout got %0d accepts required 3", acc); end
   endtask

   task automatic test_fault();
      step();
      core_if.instr_ready = 1'b0;
      repeat (2) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      push_stream(32'h40);
      @(negedge clk);
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_early got %b required 0", fault); end
      step();
      redirect_valid      = 1'b0;
      core_if.instr_ready = 1'b1;
      @(negedge clk);
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_pulse got %b required 1", fault); end
      @(negedge clk);
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_len got %b required 0", fault); end
      acc = 0;
      for (int i = 0; i < 20 && acc < 3; i++) @(negedge clk);
      total++; if (acc < 3) begin bad++; $display("FAIL fault_timeout got %0d accepts required 3", acc); end
   endtask

   task automatic test_reset_mid();
      repeat (3) step();
      rst_n = 1'b0;
      push_stream(32'h0);
      #1;
      total++; if (core_if.instr_valid !== 1'b0 || sram_csb !== 1'b1 || core_if.instr_pc !== 32'h0 || core_if.instr_data !== 32'h0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst got v=%b csb=%b pc=%h d=%h f=%b required 0/1/0/0/0",
                  core_if.instr_valid, sram_csb, core_if.instr_pc, core_if.instr_data, fault);
      end
      repeat (2) step();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (sram_csb !== 1'b0 || sram_addr !== 8'd0) begin bad++; $display("FAIL mid_first got csb=%b addr=%h required 0/00", sram_csb, sram_addr); end
      total++; if (core_if.instr_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got valid=%b required 0", core_if.instr_valid); end
      acc = 0;
      for (int i = 0; i < 20 && acc < 4; i++) @(negedge clk);
      total++; if (acc < 4) begin bad++; $display("FAIL mid_timeout got %0d accepts required 4", acc); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      acc   = 0;
      for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'(i), 8'(~i)};
      sram_dout           = 32'hDEAD_BEEF;
      rst_n               = 1'b0;
      redirect_valid      = 1'b0;
      redirect_pc         = 32'h0;
      core_if.instr_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_fault();
      test_reset_mid();
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
